// File: rtl/ysyx_23060077_riscv_mem_lsu_if.sv
// EX->LSU, LSU<->data-memory and LSU->WB handshake bundle of the memory-access stage.
// lsu_misalign is present only when YSYX_23060077_LSU_MISALIGN_CHECK_EN is defined.
interface ysyx_23060077_riscv_mem_lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic                    ex_valid;
    logic                    ex_ready;
    logic [INST_WIDTH-1:0]   inst_ex_to_mem;
    logic [DATA_WIDTH-1:0]   alu_out_data_ex;
    logic [DATA_WIDTH-1:0]   rs2_data_ex;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic                    mem_wen;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wmask;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [4:0]              wb_rd;
    logic                    wb_wen;
    logic [DATA_WIDTH-1:0]   wb_data;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    logic                    lsu_misalign;
`endif

    // LSU side
    modport master (
        input  ex_valid, inst_ex_to_mem, alu_out_data_ex, rs2_data_ex,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, wb_ready,
        output ex_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output wb_valid, wb_rd, wb_wen, wb_data
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        , output lsu_misalign
`endif
    );

    // EX / memory / WB side
    modport slave (
        output ex_valid, inst_ex_to_mem, alu_out_data_ex, rs2_data_ex,
        output mem_req_ready, mem_rsp_valid, mem_rdata, wb_ready,
        input  ex_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  wb_valid, wb_rd, wb_wen, wb_data
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        , input lsu_misalign
`endif
    );
endinterface

// File: rtl/ysyx_23060077_riscv_mem_lsu.sv
// Memory-access stage: LOAD/STORE run a valid/ready memory transaction, other opcodes reach WB one cycle later.
// Define YSYX_23060077_LSU_MISALIGN_CHECK_EN to trap misaligned accesses (flagged on lsu_misalign) instead of issuing them.
module ysyx_23060077_riscv_mem_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    ysyx_23060077_riscv_mem_lsu_if.master        bus
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned RD_WIDTH   = 5;
    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [6:0]  OP_STORE   = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    state_e state_q, state_d;

    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  is_store_q, is_store_d;
    logic                  ex_ready_q, ex_ready_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [MASK_WIDTH-1:0] mem_wmask_q, mem_wmask_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [RD_WIDTH-1:0]   wb_rd_q, wb_rd_d;
    logic                  wb_wen_q, wb_wen_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [RD_WIDTH-1:0]   rd;
    logic [1:0]            off;
    logic                  is_load, is_store, is_mem, accept, misalign;
    logic [MASK_WIDTH-1:0] st_mask;
    logic [DATA_WIDTH-1:0] st_data, ld_shift, ld_data;
    logic                  unused_inst;

    // Decode of the instruction offered by EX
    assign opcode      = bus.inst_ex_to_mem[6:0];
    assign rd          = bus.inst_ex_to_mem[11:7];
    assign funct3      = bus.inst_ex_to_mem[14:12];
    assign off         = bus.alu_out_data_ex[1:0];
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_mem      = is_load || is_store;
    assign accept      = bus.ex_valid && (state_q == S_IDLE);
    assign unused_inst = ^{bus.inst_ex_to_mem[INST_WIDTH-1:15]};

`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    logic size_byte, size_half, misalign_q, misalign_d;
    assign size_byte = is_load ? (funct3[1:0] == 2'b00) : (funct3 == 3'b000);
    assign size_half = is_load ? (funct3[1:0] == 2'b01) : (funct3 == 3'b001);
    assign misalign  = is_mem && (size_half ? off[0] : (!size_byte && (off != 2'b00)));
    assign bus.lsu_misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Store lane placement; lanes shifted past the top byte are dropped
    always_comb begin
        case (funct3)
            3'b000: begin
                st_mask = MASK_WIDTH'(4'b0001 << off);
                st_data = DATA_WIDTH'({4{bus.rs2_data_ex[7:0]}});
            end
            3'b001: begin
                st_mask = MASK_WIDTH'(4'b0011 << off);
                st_data = DATA_WIDTH'({2{bus.rs2_data_ex[15:0]}});
            end
            default: begin
                st_mask = MASK_WIDTH'(4'b1111 << off);
                st_data = bus.rs2_data_ex;
            end
        endcase
    end

    // Load extraction; upper bytes read as zero when the access runs off the word
    assign ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (funct3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            funct3_q        <= '0;
            off_q           <= '0;
            rd_q            <= '0;
            is_store_q      <= 1'b0;
            ex_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_wen_q        <= 1'b0;
            wb_data_q       <= '0;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
            misalign_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            funct3_q        <= funct3_d;
            off_q           <= off_d;
            rd_q            <= rd_d;
            is_store_q      <= is_store_d;
            ex_ready_q      <= ex_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_wen_q        <= wb_wen_d;
            wb_data_q       <= wb_data_d;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
            misalign_q      <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (is_mem && !misalign) ? S_REQ : S_DONE;
            S_REQ:   if (bus.mem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (bus.mem_rsp_valid) state_d = S_DONE;
            S_DONE:  if (bus.wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags follow the next state so they appear registered on entry
    always_comb begin
        ex_ready_d      = (state_d == S_IDLE);
        mem_req_valid_d = (state_d == S_REQ);
        wb_valid_d      = (state_d == S_DONE);
        funct3_d        = funct3_q;
        off_d           = off_q;
        rd_d            = rd_q;
        is_store_d      = is_store_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        wb_rd_d         = wb_rd_q;
        wb_wen_d        = wb_wen_q;
        wb_data_d       = wb_data_q;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
        misalign_d      = misalign_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                funct3_d   = funct3;
                off_d      = off;
                rd_d       = rd;
                is_store_d = is_store;
                if (is_mem && !misalign) begin
                    mem_addr_d  = {bus.alu_out_data_ex[DATA_WIDTH-1:2], 2'b00};
                    mem_wen_d   = is_store;
                    mem_wmask_d = is_store ? st_mask : '0;
                    mem_wdata_d = is_store ? st_data : '0;
                end else begin
                    wb_rd_d   = rd;
                    wb_wen_d  = !is_mem && (opcode != OP_BRANCH) && (rd != '0);
                    wb_data_d = is_mem ? '0 : bus.alu_out_data_ex;
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
                    misalign_d = misalign;
`endif
                end
            end
            S_WAIT: if (bus.mem_rsp_valid) begin
                wb_rd_d   = rd_q;
                wb_wen_d  = !is_store_q && (rd_q != '0);
                wb_data_d = is_store_q ? '0 : ld_data;
            end
            S_DONE: begin
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
                if (bus.wb_ready) misalign_d = 1'b0;
`endif
            end
            default: begin
            end
        endcase
    end

    assign bus.ex_ready      = ex_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_wen        = wb_wen_q;
    assign bus.wb_data       = wb_data_q;
endmodule
